ipbase_intf_pipeline_dn: RTL and testbench
==========================================

Name: ipbase_intf_pipeline_dn

Overview:
Parametrised successor to the two-entry valid/ready pipeline stage: a DEPTH-entry first-word-fall-through register buffer with fully registered upstream ready.
- id_rdy never depends combinationally on od_rdy, so ready fan-out and timing paths are cut at any depth.
- Adds synchronous flush, occupancy level, a registered almost-full flag and a sticky high-water mark.
- Used between datapath stages and as a small elastic buffer in front of credit/backpressure boundaries.

Parameters:
DATA_WIDTH, 512, payload width in bits (>=1)
DEPTH, 4, number of entries (>=2, need not be a power of two)
AFULL_THRESH, DEPTH-1, afull asserts when level >= AFULL_THRESH (1..DEPTH)
LW, $clog2(DEPTH+1), derived width of level/watermark (localparam, not overridable)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
flush  input  1  synchronous discard of all contents
id  input  DATA_WIDTH  upstream data
id_vld  input  1  upstream valid
id_rdy  output  1  upstream ready, registered
od  output  DATA_WIDTH  downstream data, zero when od_vld=0
od_vld  output  1  downstream valid, registered
od_rdy  input  1  downstream ready
level  output  LW  current entry count 0..DEPTH
afull  output  1  registered almost-full
hwm  output  LW  sticky maximum level since reset/flush

Behaviour:
- Interface decision: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: id_rdy=1, od_vld=0, od=0, level=0, afull=0, hwm=0. Both pointers are 0. Storage array is not reset.
- Handshakes:
  - push = id_vld & id_rdy; pop = od_vld & od_rdy.
  - Upstream may hold id_vld with changing id while id_rdy=0; nothing is captured.
- Storage and pointers:
  - Array mem[DEPTH] with write pointer wp and read pointer rp.
  - Each pointer wraps from DEPTH-1 to 0 by explicit compare, not by bit truncation.
  - od = od_vld ? mem[rp] : 0. There is no combinational path from id to od.
- Count update:
  - push only: count+1. pop only: count-1. Both or neither: count unchanged.
  - Both push and pop with count=1 is legal: the head is replaced, od_vld stays 1 and there is no bubble.
- Registered status, all computed from next-state count:
  - id_rdy <= (count_next != DEPTH).
  - od_vld <= (count_next != 0).
  - afull <= (count_next >= AFULL_THRESH).
  - level mirrors the count register.
- Full: id_rdy=0, so no push occurs even if a pop happens in the same cycle. id_rdy returns to 1 the cycle after the pop. This is intentional: ready is never derived from od_rdy.
- Empty: od_vld=0. A push into an empty buffer appears on od the next cycle (latency 1). There is no same-cycle pass-through.
- Throughput: 1 word/cycle sustained while 1 <= level <= DEPTH-1.
- hwm <= max(hwm, count_next) each cycle.
- flush:
  - Next cycle: count=0, wp=rp=0, od_vld=0, id_rdy=1, afull=0, hwm=0.
  - flush overrides a same-cycle push and pop. The upstream word is consumed and discarded if id_rdy was 1.
- Async reset mid-transfer immediately forces all reset values. The in-flight word is lost and no partial state survives.
- Ordering: strict FIFO. No duplication or loss except by flush or reset.

Decomposition:
- Shared package ipbase_pkg:
  - function clog2_min1(n), returns at least 1 bit.
  - function wrap_inc(ptr, depth).
- Sub-module ipbase_ptr_wrap: pointer register with enable, synchronous clear and wrap at DEPTH-1. Instantiated twice (wp, rp).
- Storage, count and flag logic stay in the top module.

Test Plan:
- DEPTH=4, od_rdy=1, push 0x11..0x18 back-to-back -> first od_vld one cycle after first push; 8 words out in order; level never exceeds 1.
- DEPTH=4, od_rdy=0, id_vld=1 for 6 cycles -> id_rdy falls after 4 pushes; level=4, afull=1 once level>=3, hwm=4. Raise od_rdy -> 0x11 out first; id_rdy=1 one cycle after first pop.
- Full with id_vld=1, od_rdy=1 in the same cycle -> exactly one pop, no push that cycle; level=3 next cycle.
- level=2, pulse flush with id_vld=1 -> next cycle od_vld=0, level=0, hwm=0, id_rdy=1; od=0; the subsequent word 0xAA is the next word out.
- DEPTH=3 (non power of two), random id_vld/od_rdy for 10k cycles against a scoreboard -> order preserved, pointers wrap 2->0, id_rdy has no combinational dependency on od_rdy (checked by assertion).
- Assert rst asynchronously mid-burst at level=2 -> outputs take reset values before the next clk edge; after release the first pushed word emerges correctly.

Source files
------------

// File: rtl/ipbase_pkg.sv
// Shared helpers for the ipbase pipeline/buffer blocks.
package ipbase_pkg;

    // Handshake activity in one cycle, encoded as {pop, push}.
    typedef enum logic [1:0] {
        OpIdle = 2'b00,
        OpPush = 2'b01,
        OpPop  = 2'b10,
        OpBoth = 2'b11
    } op_e;

    // Pointer width for an index range of n entries, never narrower than 1 bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Increment with explicit wrap at depth-1, so non power-of-two depths work.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/ipbase_ptr_wrap.sv
// Circular pointer register: enable, synchronous clear, wrap at DEPTH-1.
module ipbase_ptr_wrap
    import ipbase_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PW    = clog2_min1(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_clr,
    output logic [PW-1:0] o_ptr
);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_inc;

    // Next pointer value, wrapping by compare rather than bit truncation.
    always_comb begin
        w_ptr_inc = PW'(wrap_inc(32'(r_ptr), DEPTH));
    end

    // Pointer register; clear has priority over advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= w_ptr_inc;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/ipbase_intf_pipeline_dn.sv
// DEPTH-entry first-word-fall-through register buffer with registered upstream ready,
// synchronous flush, occupancy level, registered almost-full and sticky high-water mark.
module ipbase_intf_pipeline_dn
    import ipbase_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 512,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned AFULL_THRESH = DEPTH - 1,
    localparam int unsigned LW          = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] id,
    input  logic                  id_vld,
    output logic                  id_rdy,
    output logic [DATA_WIDTH-1:0] od,
    output logic                  od_vld,
    input  logic                  od_rdy,
    output logic [LW-1:0]         level,
    output logic                  afull,
    output logic [LW-1:0]         hwm
);

    localparam int unsigned PW = clog2_min1(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [LW-1:0]         r_count;
    logic                  r_id_rdy;
    logic                  r_od_vld;
    logic                  r_afull;
    logic [LW-1:0]         r_hwm;

    logic                  w_push;
    logic                  w_pop;
    op_e                   w_op;
    logic [LW-1:0]         w_count_nxt;
    logic [LW-1:0]         w_hwm_nxt;
    logic [PW-1:0]         w_wp;
    logic [PW-1:0]         w_rp;

    // Handshakes use only registered ready/valid, so no od_rdy -> id_rdy path exists.
    assign w_push = id_vld & r_id_rdy;
    assign w_pop  = r_od_vld & od_rdy;

    // Write pointer: advances on an accepted word; a flushed word is discarded.
    ipbase_ptr_wrap #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_wp (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_push & ~flush),
        .i_clr (flush),
        .o_ptr (w_wp)
    );

    // Read pointer: advances when the head is taken downstream.
    ipbase_ptr_wrap #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_rp (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_pop & ~flush),
        .i_clr (flush),
        .o_ptr (w_rp)
    );

    // Storage write; the array carries no reset, validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[w_wp] <= id;
        end
    end

    // Next-state occupancy; push+pop together leaves the count unchanged.
    always_comb begin
        w_op        = op_e'({w_pop, w_push});
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = '0;
        end else begin
            case (w_op)
                OpPush:  w_count_nxt = r_count + 1'b1;
                OpPop:   w_count_nxt = r_count - 1'b1;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Next high-water mark; flush restarts tracking from zero.
    always_comb begin
        w_hwm_nxt = r_hwm;
        if (flush) begin
            w_hwm_nxt = '0;
        end else if (w_count_nxt > r_hwm) begin
            w_hwm_nxt = w_count_nxt;
        end
    end

    // Count and status flags, all registered from the next-state count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_id_rdy <= 1'b1;
            r_od_vld <= 1'b0;
            r_afull  <= 1'b0;
            r_hwm    <= '0;
        end else begin
            r_count  <= w_count_nxt;
            r_id_rdy <= (w_count_nxt != LW'(DEPTH));
            r_od_vld <= (w_count_nxt != '0);
            r_afull  <= (w_count_nxt >= LW'(AFULL_THRESH));
            r_hwm    <= w_hwm_nxt;
        end
    end

    // Head of the buffer, forced to zero while nothing valid is presented.
    always_comb begin
        od = '0;
        if (r_od_vld) begin
            od = r_mem[w_rp];
        end
    end

    assign id_rdy = r_id_rdy;
    assign od_vld = r_od_vld;
    assign level  = r_count;
    assign afull  = r_afull;
    assign hwm    = r_hwm;

endmodule

// File: tb/tb_ipbase_intf_pipeline_dn.sv
// Bench for ipbase_intf_pipeline_dn: DEPTH=4 directed steps and DEPTH=3 random traffic,
// each checked every cycle against a queue-based reference.
module tb_ipbase_intf_pipeline_dn;

    localparam int unsigned D4  = 4;
    localparam int unsigned TH4 = 3;
    localparam int unsigned D3  = 3;
    localparam int unsigned TH3 = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       flush4 = 1'b0;
    logic [7:0] id4 = 8'h00;
    logic       id_vld4 = 1'b0;
    logic       id_rdy4;
    logic [7:0] od4;
    logic       od_vld4;
    logic       od_rdy4 = 1'b0;
    logic [2:0] level4;
    logic       afull4;
    logic [2:0] hwm4;

    logic        flush3 = 1'b0;
    logic [15:0] id3 = 16'h0000;
    logic        id_vld3 = 1'b0;
    logic        id_rdy3;
    logic [15:0] od3;
    logic        od_vld3;
    logic        od_rdy3 = 1'b0;
    logic [1:0]  level3;
    logic        afull3;
    logic [1:0]  hwm3;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pop4  = 0;
    int n_pop3  = 0;

    logic [7:0]  q4 [$];
    logic [15:0] q3 [$];
    int          mhwm4 = 0;
    int          mhwm3 = 0;

    always #5 clk = ~clk;

    ipbase_intf_pipeline_dn #(
        .DATA_WIDTH (8),
        .DEPTH      (D4)
    ) dut4 (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush4),
        .id     (id4),
        .id_vld (id_vld4),
        .id_rdy (id_rdy4),
        .od     (od4),
        .od_vld (od_vld4),
        .od_rdy (od_rdy4),
        .level  (level4),
        .afull  (afull4),
        .hwm    (hwm4)
    );

    ipbase_intf_pipeline_dn #(
        .DATA_WIDTH (16),
        .DEPTH      (D3)
    ) dut3 (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush3),
        .id     (id3),
        .id_vld (id_vld3),
        .id_rdy (id_rdy3),
        .od     (od3),
        .od_vld (od_vld3),
        .od_rdy (od_rdy3),
        .level  (level3),
        .afull  (afull3),
        .hwm    (hwm3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference update at the active edge: expected words queued on push, dropped on pop.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            q4.delete();
            q3.delete();
            mhwm4 = 0;
            mhwm3 = 0;
        end else begin
            if (flush4) begin
                q4.delete();
                mhwm4 = 0;
            end else begin
                automatic bit pu = id_vld4 && (q4.size() != D4);
                automatic bit po = (q4.size() != 0) && od_rdy4;
                if (po) begin
                    void'(q4.pop_front());
                    n_pop4++;
                end
                if (pu) q4.push_back(id4);
                if (q4.size() > mhwm4) mhwm4 = q4.size();
            end
            if (flush3) begin
                q3.delete();
                mhwm3 = 0;
            end else begin
                automatic bit pu = id_vld3 && (q3.size() != D3);
                automatic bit po = (q3.size() != 0) && od_rdy3;
                if (po) begin
                    void'(q3.pop_front());
                    n_pop3++;
                end
                if (pu) q3.push_back(id3);
                if (q3.size() > mhwm3) mhwm3 = q3.size();
            end
        end
    end

    // Mid-cycle comparison of every output against the reference.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            automatic logic [7:0]  e4 = (q4.size() != 0) ? q4[0] : 8'h00;
            automatic logic [15:0] e3 = (q3.size() != 0) ? q3[0] : 16'h0000;
            chk("m4_id_rdy", id_rdy4, q4.size() != D4);
            chk("m4_od_vld", od_vld4, q4.size() != 0);
            chk("m4_od",     od4,     e4);
            chk("m4_level",  level4,  q4.size());
            chk("m4_afull",  afull4,  q4.size() >= TH4);
            chk("m4_hwm",    hwm4,    mhwm4);
            chk("m3_id_rdy", id_rdy3, q3.size() != D3);
            chk("m3_od_vld", od_vld3, q3.size() != 0);
            chk("m3_od",     od3,     e3);
            chk("m3_level",  level3,  q3.size());
            chk("m3_afull",  afull3,  q3.size() >= TH3);
            chk("m3_hwm",    hwm3,    mhwm3);
        end
    end

    initial begin
        int p0;
        logic r0;

        // Reset
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_id_rdy", id_rdy4, 1);
        chk("rst_od_vld", od_vld4, 0);
        chk("rst_od",     od4,     0);
        chk("rst_level",  level4,  0);
        chk("rst_afull",  afull4,  0);
        chk("rst_hwm",    hwm4,    0);

        // Streaming with od_rdy=1: latency 1, level stays <= 1
        p0 = n_pop4;
        @(posedge clk); #1;
        od_rdy4 = 1'b1;
        id_vld4 = 1'b1;
        id4     = 8'h11;
        chk("t1_pre_vld", od_vld4, 0);
        for (int i = 1; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 1) chk("t1_latency", od_vld4, 1);
            chk("t1_level_le1", level4 <= 1, 1);
            id4 = 8'h11 + 8'(i);
        end
        @(posedge clk); #1;
        id_vld4 = 1'b0;
        chk("t1_level_le1", level4 <= 1, 1);
        repeat (2) @(posedge clk);
        #1 chk("t1_words_out", n_pop4 - p0, 8);

        // Fill with od_rdy=0
        od_rdy4 = 1'b0;
        id_vld4 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            id4 = 8'h10 + 8'(k);
            @(posedge clk); #1;
            chk("t2_level",  level4, (k > 4) ? 4 : k);
            chk("t2_afull",  afull4, k >= 3);
            chk("t2_id_rdy", id_rdy4, k < 4);
        end
        chk("t2_hwm", hwm4, 4);

        // Full with id_vld and od_rdy together: one pop, no push
        id4     = 8'h77;
        od_rdy4 = 1'b1;
        chk("t3_head", od4, 8'h11);
        @(posedge clk); #1;
        id_vld4 = 1'b0;
        chk("t3_level",  level4,  3);
        chk("t3_id_rdy", id_rdy4, 1);
        chk("t3_next",   od4,     8'h12);
        repeat (4) @(posedge clk);
        #1 chk("t3_drained", level4, 0);

        // Flush at level 2 with a same-cycle push
        od_rdy4 = 1'b0;
        id_vld4 = 1'b1;
        id4     = 8'h21;
        @(posedge clk); #1 id4 = 8'h22;
        @(posedge clk); #1;
        chk("t4_level2", level4, 2);
        flush4 = 1'b1;
        id4    = 8'h23;
        @(posedge clk); #1;
        flush4 = 1'b0;
        id4    = 8'hAA;
        chk("t4_od_vld", od_vld4, 0);
        chk("t4_level",  level4,  0);
        chk("t4_hwm",    hwm4,    0);
        chk("t4_id_rdy", id_rdy4, 1);
        chk("t4_od",     od4,     0);
        @(posedge clk); #1;
        id_vld4 = 1'b0;
        chk("t4_next_word", od4, 8'hAA);
        od_rdy4 = 1'b1;
        repeat (2) @(posedge clk);

        // Async reset mid-burst at level 2
        #1;
        od_rdy4 = 1'b0;
        id_vld4 = 1'b1;
        id4     = 8'h31;
        @(posedge clk); #1 id4 = 8'h32;
        @(posedge clk); #1 id4 = 8'h33;
        chk("t5_level2", level4, 2);
        @(negedge clk); #2 rst = 1'b1;
        #1;
        chk("t5_od_vld", od_vld4, 0);
        chk("t5_level",  level4,  0);
        chk("t5_id_rdy", id_rdy4, 1);
        chk("t5_hwm",    hwm4,    0);
        chk("t5_afull",  afull4,  0);
        chk("t5_od",     od4,     0);
        @(posedge clk); #1;
        rst     = 1'b0;
        id4     = 8'h41;
        od_rdy4 = 1'b1;
        @(posedge clk); #1;
        id_vld4 = 1'b0;
        chk("t5_first_out", od4, 8'h41);
        repeat (2) @(posedge clk);

        // DEPTH=3 random traffic; od_rdy wiggled mid-cycle must not move id_rdy
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk); #1;
            id_vld3 = 1'($urandom_range(0, 1));
            id3     = 16'($urandom);
            od_rdy3 = 1'($urandom_range(0, 1));
            flush3  = ($urandom_range(0, 199) == 0);
            #1;
            r0      = id_rdy3;
            od_rdy3 = ~od_rdy3;
            #1 chk("t6_rdy_comb", id_rdy3, r0);
            od_rdy3 = ~od_rdy3;
        end
        @(posedge clk); #1;
        id_vld3 = 1'b0;
        flush3  = 1'b0;
        chk("t6_traffic", n_pop3 > 1000, 1);
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
